// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stages: per-boundary widths,
// occupancy encodings and control-bit field offsets used by stage wrappers.
package pipe_pkg;

  localparam int IFID_DATA_W  = 64;
  localparam int IFID_CTRL_W  = 4;
  localparam int IDEX_DATA_W  = 96;
  localparam int IDEX_CTRL_W  = 18;
  localparam int EXMEM_DATA_W = 48;
  localparam int EXMEM_CTRL_W = 14;
  localparam int MEMWB_DATA_W = 40;
  localparam int MEMWB_CTRL_W = 6;

  // State of the stage is simply how many entries it holds.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // EX/MEM control-bit layout, shared so pack and unpack always agree.
  localparam int EXMEM_MEMREAD   = 0;
  localparam int EXMEM_MEMWRITE  = 1;
  localparam int EXMEM_REGWRITE  = 2;
  localparam int EXMEM_PUSH      = 3;
  localparam int EXMEM_POP       = 4;
  localparam int EXMEM_SHMNT_LSB = 5;
  localparam int EXMEM_SHMNT_W   = 5;
  localparam int EXMEM_RD_LSB    = 10;
  localparam int EXMEM_RD_W      = 4;

  // MEM/WB control-bit layout.
  localparam int MEMWB_REGWRITE  = 0;
  localparam int MEMWB_MEMTOREG  = 1;
  localparam int MEMWB_RD_LSB    = 2;
  localparam int MEMWB_RD_W      = 4;

endpackage

// File: rtl/pipe_stage_elastic_sat_counter.sv
// Saturating up-counter with enable and asynchronous clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic two-entry (main + skid) pipeline register with valid/ready handshake,
// synchronous flush, bubble masking of control bits and a stall-cycle counter.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W    = EXMEM_DATA_W,
  parameter int CTRL_W    = EXMEM_CTRL_W,
  parameter int CNT_W     = 16,
  parameter bit MASK_CTRL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        occupancy
);

  occ_e              state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid  & in_ready;
  assign out_xfer = out_valid & out_ready;

  // NOTE: payload registers are reset too, so out_data/out_ctrl read 0 straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= OCC_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  // Flush only clears occupancy; held payloads go stale and are never exposed as valid.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      unique case (state_q)
        OCC_EMPTY: begin
          if (in_xfer) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
            state_d     = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (in_xfer && out_xfer) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (out_xfer) begin
            state_d = OCC_EMPTY;
          end else if (in_xfer) begin
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
            state_d     = OCC_FULL;
          end
        end
        OCC_FULL: begin
          if (out_xfer) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            state_d     = OCC_ONE;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  // All handshake outputs derive from registered state only.
  always_comb begin
    in_ready  = (state_q != OCC_FULL);
    out_valid = (state_q != OCC_EMPTY);
    occupancy = state_q;
    out_data  = main_data_q;
    out_ctrl  = main_ctrl_q;
    if (MASK_CTRL && (state_q == OCC_EMPTY)) out_ctrl = '0;
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (out_valid & ~out_ready & ~flush),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_pipe_stage_elastic;

  localparam int DATA_W = 48;
  localparam int CTRL_W = 14;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_ready;

  logic              in_ready_a, out_valid_a;
  logic [DATA_W-1:0] out_data_a;
  logic [CTRL_W-1:0] out_ctrl_a;
  logic [15:0]       stall_cnt_a;
  logic [1:0]        occupancy_a;

  logic              in_ready_b, out_valid_b;
  logic [DATA_W-1:0] out_data_b;
  logic [CTRL_W-1:0] out_ctrl_b;
  logic [3:0]        stall_cnt_b;
  logic [1:0]        occupancy_b;

  pipe_stage_elastic #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(16), .MASK_CTRL(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_ctrl(out_ctrl_a), .stall_cnt(stall_cnt_a), .occupancy(occupancy_a)
  );

  // Unmasked variant with a narrow counter, driven by the same stimulus.
  pipe_stage_elastic #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(4), .MASK_CTRL(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_ctrl(out_ctrl_b), .stall_cnt(stall_cnt_b), .occupancy(occupancy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a two-deep FIFO, plus stall counters and the last head ctrl.
  typedef struct {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  entry_t            mq[$];
  int                m_stall16 = 0;
  int                m_stall4  = 0;
  logic [CTRL_W-1:0] m_last_ctrl = '0;

  always @(posedge clk or posedge rst) begin : model
    int n;
    bit ox, ix;
    entry_t e;
    if (rst) begin
      mq.delete();
      m_stall16   = 0;
      m_stall4    = 0;
      m_last_ctrl = '0;
    end else if (flush) begin
      mq.delete();
    end else begin
      n  = mq.size();
      ox = (n > 0) && out_ready;
      ix = in_valid && (n < 2);
      if ((n > 0) && !out_ready) begin
        if (m_stall16 < 65535) m_stall16++;
        if (m_stall4  < 15)    m_stall4++;
      end
      if (ox) void'(mq.pop_front());
      if (ix) begin
        e.data = in_data;
        e.ctrl = in_ctrl;
        mq.push_back(e);
      end
      if (mq.size() > 0) m_last_ctrl = mq[0].ctrl;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", 64'(out_valid_a), 64'(mq.size() > 0));
      check("occupancy", 64'(occupancy_a), 64'(mq.size()));
      check("in_ready",  64'(in_ready_a),  64'(mq.size() < 2));
      check("in_ready_b", 64'(in_ready_b), 64'(mq.size() < 2));
      check("stall_cnt", 64'(stall_cnt_a), 64'(m_stall16));
      check("stall_cnt_b", 64'(stall_cnt_b), 64'(m_stall4));
      if (mq.size() > 0) begin
        check("out_data", 64'(out_data_a), 64'(mq[0].data));
        check("out_ctrl", 64'(out_ctrl_a), 64'(mq[0].ctrl));
        check("out_data_b", 64'(out_data_b), 64'(mq[0].data));
      end else begin
        check("out_ctrl_masked", 64'(out_ctrl_a), 64'(0));
      end
      check("out_ctrl_b", 64'(out_ctrl_b), 64'((mq.size() > 0) ? mq[0].ctrl : m_last_ctrl));
    end
  end

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = r;
    flush     = f;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid_a), 64'(0));
    check("rst_in_ready",  64'(in_ready_a),  64'(1));
    check("rst_occupancy", 64'(occupancy_a), 64'(0));
    check("rst_out_ctrl",  64'(out_ctrl_a),  64'(0));
    check("rst_out_data",  64'(out_data_a),  64'(0));
    check("rst_stall_cnt", 64'(stall_cnt_a), 64'(0));
    @(negedge clk);
    tick();
    rst    = 1'b0;
    chk_en = 1'b1;

    // Streaming with out_ready held high.
    drive(1'b1, 48'h1, 14'h011, 1'b1, 1'b0);
    tick();
    check("stream_1", 64'(out_data_a), 64'h1);
    check("stream_rdy1", 64'(in_ready_a), 64'(1));
    drive(1'b1, 48'h2, 14'h022, 1'b1, 1'b0);
    tick();
    check("stream_2", 64'(out_data_a), 64'h2);
    drive(1'b1, 48'h3, 14'h033, 1'b1, 1'b0);
    tick();
    check("stream_3", 64'(out_data_a), 64'h3);
    check("stream_stall", 64'(stall_cnt_a), 64'(0));
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    check("stream_drained", 64'(out_valid_a), 64'(0));

    // Back-pressure: fill main and skid, hold off a third entry.
    drive(1'b1, 48'hA, 14'h0A0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 48'hB, 14'h0B0, 1'b0, 1'b0);
    tick();
    check("bp_full_occ", 64'(occupancy_a), 64'(2));
    check("bp_full_rdy", 64'(in_ready_a), 64'(0));
    drive(1'b1, 48'hC, 14'h0C0, 1'b0, 1'b0);
    tick();
    check("bp_stall_2", 64'(stall_cnt_a), 64'(2));
    check("bp_model_stall", 64'(m_stall16), 64'(2));
    check("bp_head_A", 64'(out_data_a), 64'hA);
    drive(1'b1, 48'hC, 14'h0C0, 1'b1, 1'b0);
    tick();
    check("bp_head_B", 64'(out_data_a), 64'hB);
    check("bp_occ_1", 64'(occupancy_a), 64'(1));
    tick();
    check("bp_head_C", 64'(out_data_a), 64'hC);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    check("bp_empty", 64'(out_valid_a), 64'(0));
    check("bp_stall_kept", 64'(stall_cnt_a), 64'(2));

    // Flush while full, with a new entry offered in the flush cycle.
    drive(1'b1, 48'hD, 14'h0D0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 48'hE, 14'h0E0, 1'b0, 1'b0);
    tick();
    check("fl_full", 64'(occupancy_a), 64'(2));
    drive(1'b1, 48'hF, 14'h0F0, 1'b0, 1'b1);
    tick();
    check("fl_valid", 64'(out_valid_a), 64'(0));
    check("fl_occ",   64'(occupancy_a), 64'(0));
    check("fl_rdy",   64'(in_ready_a),  64'(1));
    check("fl_ctrl",  64'(out_ctrl_a),  64'(0));
    check("fl_stall", 64'(stall_cnt_a), 64'(3));
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    check("fl_nothing", 64'(out_valid_a), 64'(0));

    // Bubble masking: all-ones ctrl accepted, then drained.
    drive(1'b1, 48'h5, '1, 1'b1, 1'b0);
    tick();
    check("mask_live_a", 64'(out_ctrl_a), 64'h3FFF);
    check("mask_live_b", 64'(out_ctrl_b), 64'h3FFF);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    check("mask_bubble_a", 64'(out_ctrl_a), 64'h0);
    check("mask_bubble_b", 64'(out_ctrl_b), 64'h3FFF);

    // Saturation of the 4-bit counter over 20 stalled cycles.
    drive(1'b1, 48'h6, 14'h006, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    check("sat_b", 64'(stall_cnt_b), 64'd15);
    check("sat_a", 64'(stall_cnt_a), 64'd23);
    #2 rst = 1'b1;
    #1;
    check("sat_rst_a", 64'(stall_cnt_a), 64'(0));
    check("sat_rst_b", 64'(stall_cnt_b), 64'(0));
    check("sat_rst_valid", 64'(out_valid_a), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic with occasional flush and mid-cycle reset.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) < 70), {$urandom(), $urandom()},
            CTRL_W'($urandom()), ($urandom_range(0, 99) < 55),
            ($urandom_range(0, 99) < 3));
      rst = 1'b0;
      if ($urandom_range(0, 199) == 0) #2 rst = 1'b1;
      @(negedge clk);
    end
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
